int_to_float: RTL

- Converts a 32-bit integer to an IEEE-754 single-precision float.
- Sits directly upstream of the float arithmetic units (divider, multiplier, adder) and drives their input_a/input_b ports.
- Both sides use the codebase's 16-bit two-word stb/ack bus: high word first, then low word.
- Rounding is round-to-nearest-even; the result is always finite.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/lzc32.sv | 17 +
 rtl/int_to_float.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, state encoding and float field layout
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;
    localparam int BUS_W    = 16;

    localparam logic [3:0] ST_GET_HI    = 4'd0;
    localparam logic [3:0] ST_GET_LO    = 4'd1;
    localparam logic [3:0] ST_CONVERT   = 4'd2;
    localparam logic [3:0] ST_NORMALISE = 4'd3;
    localparam logic [3:0] ST_ROUND     = 4'd4;
    localparam logic [3:0] ST_PACK      = 4'd5;
    localparam logic [3:0] ST_PUT_HI    = 4'd6;
    localparam logic [3:0] ST_PUT_LO    = 4'd7;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MANT_W-1:0] mantissa;
    } float_t;

endpackage

// File: rtl/lzc32.sv
// rtl/lzc32.sv - combinational 32-bit leading-zero counter, returns 32 for a zero input
module lzc32 (
    input  logic [31:0] i_value,
    output logic [5:0]  o_count
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        o_count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_value[i]) begin
                o_count = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_float.sv
// rtl/int_to_float.sv - 32-bit integer to IEEE-754 single over two-word stb/ack bus; INT_TO_FLOAT_LZC_EN selects one-cycle normalise
module int_to_float
    import fpu_pkg::*;
#(
    parameter logic INPUT_SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    output logic [BUS_W-1:0] output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    logic [3:0]        r_state;
    logic              r_in_ack;
    logic              r_out_stb;
    logic [BUS_W-1:0]  r_out;
    logic [31:0]       r_a;
    logic              r_s;
    logic              r_zero;
    logic [31:0]       r_m;
    logic [EXP_W-1:0]  r_e;
    logic [MANT_W-1:0] r_frac;
    float_t            r_z;

    logic              w_sign;
    logic [31:0]       w_abs;
    logic              w_round_up;
    logic              w_carry;
    logic [MANT_W-1:0] w_frac_inc;

    // 0x80000000 negates to itself, which reads correctly as 2^31 unsigned.
    assign w_sign     = INPUT_SIGNED && r_a[31];
    assign w_abs      = w_sign ? (~r_a + 32'd1) : r_a;
    assign w_round_up = r_m[7] && (r_m[6] || (|r_m[5:0]) || r_m[8]);
    assign w_carry    = &r_m[31:8];
    // All-ones fraction wraps to zero, which is exactly the carry-out result.
    assign w_frac_inc = r_m[30:8] + 23'd1;

`ifdef INT_TO_FLOAT_LZC_EN
    logic [5:0] w_lzc;

    lzc32 u_lzc (
        .i_value (r_m),
        .o_count (w_lzc)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_GET_HI;
            r_in_ack  <= 1'b0;
            r_out_stb <= 1'b0;
            r_out     <= '0;
        end else begin
            case (r_state)
                ST_GET_HI: begin
                    r_in_ack <= 1'b1;
                    if (r_in_ack && input_a_stb) begin
                        r_a[31:16] <= input_a;
                        r_in_ack   <= 1'b0;
                        r_state    <= ST_GET_LO;
                    end
                end
                ST_GET_LO: begin
                    r_in_ack <= 1'b1;
                    if (r_in_ack && input_a_stb) begin
                        r_a[15:0] <= input_a;
                        r_in_ack  <= 1'b0;
                        r_state   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    r_s     <= w_sign;
                    r_m     <= w_abs;
                    r_e     <= 8'd31;
                    r_zero  <= (w_abs == 32'd0);
                    r_state <= (w_abs == 32'd0) ? ST_PACK : ST_NORMALISE;
                end
                ST_NORMALISE: begin
`ifdef INT_TO_FLOAT_LZC_EN
                    r_m     <= r_m << w_lzc;
                    r_e     <= 8'd31 - {2'b00, w_lzc};
                    r_state <= ST_ROUND;
`else
                    if (r_m[31]) begin
                        r_state <= ST_ROUND;
                    end else begin
                        r_m <= r_m << 1;
                        r_e <= r_e - 8'd1;
                    end
`endif
                end
                ST_ROUND: begin
                    r_frac <= w_round_up ? w_frac_inc : r_m[30:8];
                    if (w_round_up && w_carry) begin
                        r_e <= r_e + 8'd1;
                    end
                    r_state <= ST_PACK;
                end
                ST_PACK: begin
                    if (r_zero) begin
                        r_z <= '0;
                    end else begin
                        r_z.sign     <= r_s;
                        r_z.exponent <= r_e + 8'(EXP_BIAS);
                        r_z.mantissa <= r_frac;
                    end
                    r_state <= ST_PUT_HI;
                end
                ST_PUT_HI: begin
                    r_out_stb <= 1'b1;
                    r_out     <= r_z[31:16];
                    if (r_out_stb && output_z_ack) begin
                        r_out_stb <= 1'b0;
                        r_state   <= ST_PUT_LO;
                    end
                end
                ST_PUT_LO: begin
                    r_out_stb <= 1'b1;
                    r_out     <= r_z[15:0];
                    if (r_out_stb && output_z_ack) begin
                        r_out_stb <= 1'b0;
                        r_state   <= ST_GET_HI;
                    end
                end
                default: r_state <= ST_GET_HI;
            endcase
        end
    end

    assign input_a_ack  = r_in_ack;
    assign output_z     = r_out;
    assign output_z_stb = r_out_stb;

endmodule
